// File: rtl/switch_debounce_sequencer.sv
// switch_debounce_sequencer
//   Conditions four raw, bouncy front-panel inputs and drives a 3-bit code
//   for a downstream 3-to-8 decoder. In IDLE the code follows the slide
//   switches. With auto_en high the code steps up or down every AUTO_DIV
//   cycles (RUN). A button press toggles between RUN and PAUSE.
//
// Ports
//   clk      in   single clock, rising-edge
//   rst_n    in   asynchronous active-low reset
//   switch   in   [2:0] raw slide-switch code
//   btn      in   raw push button, high = pressed
//   auto_en  in   raw auto-sequencing mode switch
//   dir      in   raw direction switch, 1 = up, 0 = down
//   code     out  [2:0] registered code
//   changed  out  one-cycle pulse, the cycle after code takes a new value
//
// Handshake note: there is no valid/ready pair. "changed" acts as a valid
// strobe for code: it is high for exactly one cycle, and code is stable and
// carries the new value during that cycle.
module switch_debounce_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned AUTO_DIV        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] switch,
  input  logic       btn,
  input  logic       auto_en,
  input  logic       dir,
  output logic [2:0] code,
  output logic       changed
);

  localparam int NIN = 6;
  localparam int CW  = 16;
  localparam int PW  = 24;
  localparam logic [CW-1:0] DB_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(AUTO_DIV - 1);

  // Input bit positions in the conditioned vectors
  localparam int B_BTN  = 3;
  localparam int B_AUTO = 4;
  localparam int B_DIR  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  logic [NIN-1:0] raw;
  logic [NIN-1:0] sync1_q, sync2_q;
  logic [NIN-1:0] deb_q, deb_d;
  logic [CW-1:0]  cnt_q [NIN];
  logic [CW-1:0]  cnt_d [NIN];
  logic           btn_prev_q;
  logic           press;

  state_t         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [2:0]     code_q, code_d;
  logic [2:0]     code_prev_q;
  logic           changed_q, changed_d;

  assign raw = {dir, auto_en, btn, switch};

  // Per-input debouncer: the counter only runs while the synchronized value
  // disagrees with the accepted one, so any disagreement shorter than
  // DEBOUNCE_CYCLES is discarded.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NIN; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_MAX) begin
        cnt_d[i] = '0;
        deb_d[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  // Rising edge of the debounced button; release is deliberately ignored.
  assign press = deb_q[B_BTN] & ~btn_prev_q;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (deb_q[B_AUTO]) begin
          // Enter RUN holding the current code; steps start a full period later
          state_d = RUN;
          presc_d = '0;
        end else begin
          code_d = deb_q[2:0];
        end
      end
      RUN: begin
        // auto_en dropping beats a simultaneous press
        if (!deb_q[B_AUTO]) begin
          state_d = IDLE;
          presc_d = '0;
        end else if (press) begin
          state_d = PAUSE;
        end else if (presc_q == PRE_MAX) begin
          presc_d = '0;
          code_d  = deb_q[B_DIR] ? code_q + 3'd1 : code_q - 3'd1;
        end else begin
          presc_d = presc_q + 24'd1;
        end
      end
      PAUSE: begin
        if (!deb_q[B_AUTO]) begin
          state_d = IDLE;
          presc_d = '0;
        end else if (press) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        presc_d = '0;
      end
    endcase
  end

  // changed lags the code update by one edge, so it compares the current
  // code against the value it held one cycle earlier.
  assign changed_d = (code_q != code_prev_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
      btn_prev_q  <= 1'b0;
      state_q     <= IDLE;
      presc_q     <= '0;
      code_q      <= 3'd0;
      code_prev_q <= 3'd0;
      changed_q   <= 1'b0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      cnt_q       <= cnt_d;
      btn_prev_q  <= deb_q[B_BTN];
      state_q     <= state_d;
      presc_q     <= presc_d;
      code_q      <= code_d;
      code_prev_q <= code_q;
      changed_q   <= changed_d;
    end
  end

  assign code    = code_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_switch_debounce_sequencer.sv
// Bench for switch_debounce_sequencer with DEBOUNCE_CYCLES=4, AUTO_DIV=3.
// Directed stimulus pushes each code value the DUT is expected to announce
// into exp_q; a monitor pops one entry per changed pulse and compares it
// with code. Timing (edge counts) is checked directly by the driver.
module tb_switch_debounce_sequencer;

  localparam int DC = 4;
  localparam int AD = 3;

  logic       clk;
  logic       rst_n;
  logic [2:0] switch;
  logic       btn;
  logic       auto_en;
  logic       dir;
  logic [2:0] code;
  logic       changed;

  logic [2:0] exp_q[$];
  int n_cmp;
  int n_fail;

  switch_debounce_sequencer #(
    .DEBOUNCE_CYCLES(DC),
    .AUTO_DIV       (AD)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .switch (switch),
    .btn    (btn),
    .auto_en(auto_en),
    .dir    (dir),
    .code   (code),
    .changed(changed)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counts rising edges until code equals val; -1 if the budget runs out.
  task automatic wait_code(input logic [2:0] val, input int exp_n, input string name);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < exp_n + 20) begin
      @(posedge clk);
      #1;
      n++;
      if (code == val) hit = 1'b1;
    end
    check(name, hit ? n : -1, exp_n);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && changed) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_changed: code=%0d with no expected value", code);
      end else begin
        check("changed_code", int'(code), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    switch  = 3'd0;
    btn     = 1'b0;
    auto_en = 1'b0;
    dir     = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_code", int'(code), 0);
    check("rst_changed", int'(changed), 0);
    check("rst_state", int'(dut.state_q), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(10);

    // Two-cycle glitches 0->3->0 must be discarded
    switch = 3'd3; idle_cycles(2);
    switch = 3'd0; idle_cycles(3);
    switch = 3'd3; idle_cycles(2);
    switch = 3'd0; idle_cycles(12);
    check("glitch_code", int'(code), 0);

    // Clean 0->5 in IDLE: code at edge DC+3, changed at the next edge
    switch = 3'd5;
    exp_q.push_back(3'd5);
    wait_code(3'd5, DC + 3, "latency_code");
    check("changed_not_early", int'(changed), 0);
    @(posedge clk); #1;
    check("changed_pulse", int'(changed), 1);
    @(posedge clk); #1;
    check("changed_one_cycle", int'(changed), 0);
    idle_cycles(4);

    // Auto run up from 6: 7,0,1, one step every AUTO_DIV cycles
    switch = 3'd6;
    dir    = 1'b1;
    exp_q.push_back(3'd6);
    wait_code(3'd6, DC + 3, "load6");
    idle_cycles(4);
    auto_en = 1'b1;
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    wait_code(3'd7, DC + 3 + AD, "run_first_step");
    wait_code(3'd0, AD, "run_wrap_up");
    wait_code(3'd1, AD, "run_step_1");

    // Press one edge later: steps to 2 and 3, then pause with prescaler at 1
    @(posedge clk);
    @(negedge clk);
    btn = 1'b1;
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd3);
    wait_code(3'd2, 2, "pre_pause_2");
    wait_code(3'd3, AD, "pre_pause_3");
    idle_cycles(6);
    btn = 1'b0;
    idle_cycles(6);
    dir = 1'b0;
    idle_cycles(20);
    check("pause_frozen", int'(code), 3);

    // Resume: held prescaler (1) gives the first down-step 9 edges after press
    btn = 1'b1;
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd6);
    wait_code(3'd2, DC + 5, "resume_step");
    btn = 1'b0;
    wait_code(3'd1, AD, "down_1");
    wait_code(3'd0, AD, "down_0");
    wait_code(3'd7, AD, "wrap_down_7");
    wait_code(3'd6, AD, "down_6");

    // Pause at 4, then auto_en falls with a press in the same cycle
    switch = 3'd2;
    btn    = 1'b1;
    exp_q.push_back(3'd5);
    exp_q.push_back(3'd4);
    wait_code(3'd5, AD, "pre_pause_5");
    wait_code(3'd4, AD, "pre_pause_4");
    idle_cycles(10);
    btn = 1'b0;
    idle_cycles(12);
    check("pause2_frozen", int'(code), 4);
    btn     = 1'b1;
    auto_en = 1'b0;
    exp_q.push_back(3'd2);
    wait_code(3'd2, DC + 4, "auto_off_priority");
    btn = 1'b0;
    idle_cycles(12);
    // Press in IDLE is ignored
    btn = 1'b1; idle_cycles(10);
    btn = 1'b0; idle_cycles(10);
    check("idle_press_ignored", int'(code), 2);
    check("idle_state", int'(dut.state_q), 0);

    // Reset between edges in RUN
    switch = 3'd4;
    exp_q.push_back(3'd4);
    wait_code(3'd4, DC + 3, "load4");
    @(negedge clk);
    dir     = 1'b1;
    auto_en = 1'b1;
    exp_q.push_back(3'd5);
    wait_code(3'd5, DC + 3 + AD, "run_step_5");
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_code", int'(code), 0);
    check("async_rst_changed", int'(changed), 0);
    check("async_rst_state", int'(dut.state_q), 0);
    auto_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_code", int'(code), 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(3'd4);
    wait_code(3'd4, DC + 3, "post_rst_follow");
    check("post_rst_state", int'(dut.state_q), 0);
    idle_cycles(5);

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_debounce_sequencer.md
SWITCH_DEBOUNCE_SEQUENCER -- requirements
Module: switch_debounce_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16; consecutive stable cycles before a synchronized input is accepted; range 2..65535.
REQ-002 Parameter AUTO_DIV, default 4; clock cycles per auto-step in RUN; range 2..2^24.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous reset, active-low.
REQ-005 Port switch  input  3  raw slide-switch code, asynchronous to clk, may bounce.
REQ-006 Port btn  input  1  raw push button, asynchronous, may bounce; press = high.
REQ-007 Port auto_en  input  1  raw mode switch, asynchronous, may bounce; high selects auto-sequencing.
REQ-008 Port dir  input  1  raw direction switch; 1 = count up, 0 = count down.
REQ-009 Port code  output  3  registered 3-bit code that drives the downstream 3-to-8 decoder.
REQ-010 Port changed  output  1  registered one-cycle pulse, high in the cycle after code takes a new value.

Function
REQ-011 Each raw input (switch bits, btn, auto_en, dir) SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-012 Each synchronized signal SHALL have its own debouncer: a counter that clears whenever the synced value equals the debounced value and increments otherwise.
REQ-013 When that counter reaches DEBOUNCE_CYCLES-1 while the values still differ, the debounced value SHALL take the synced value on the same edge and the counter SHALL clear.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES synced cycles SHALL never change the debounced value.
REQ-015 A btn press event SHALL be a one-cycle pulse on the 0->1 transition of debounced btn; release SHALL generate no event.
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN, PAUSE.
REQ-017 IDLE: on every edge, code SHALL load the debounced switch value.
REQ-018 IDLE->RUN when debounced auto_en is 1; code keeps its current value and the prescaler clears to 0.
REQ-019 RUN: the prescaler counts 0..AUTO_DIV-1; when it equals AUTO_DIV-1, it wraps to 0 and code steps by +1 (dir=1) or -1 (dir=0), modulo 8.
REQ-020 Wrap-around: up from 7 SHALL give 0; down from 0 SHALL give 7; there is no saturation.
REQ-021 RUN->PAUSE on a btn press event; the prescaler holds its value and code freezes.
REQ-022 PAUSE->RUN on a btn press event; the prescaler resumes from the held value.
REQ-023 RUN or PAUSE->IDLE when debounced auto_en is 0; the prescaler clears.
REQ-024 Simultaneous debounced auto_en=0 and a btn press event SHALL go to IDLE; auto_en has priority.
REQ-025 A btn press event in IDLE SHALL be ignored.
REQ-026 A dir change takes effect on the next step; the prescaler is not disturbed.
REQ-027 changed SHALL assert exactly one cycle after each edge where code differs from its prior value; loading an equal value SHALL not assert changed.
REQ-028 Latency: a clean switch change in IDLE SHALL reach code exactly DEBOUNCE_CYCLES+3 edges after the raw change is first sampled.

Reset
REQ-029 While rst_n=0: state=IDLE, code=3'd0, changed=0, all synchronizer flops=0, debounced values=0, debounce counters=0, prescaler=0.
REQ-030 Reset asserted mid-RUN/PAUSE SHALL take effect immediately, without waiting for a clock edge; after release the block starts in IDLE and code follows the switches after debounce latency.

Verification
REQ-031 DEBOUNCE_CYCLES=4; IDLE; switch 0->5 held clean -> code=5 at edge 7 after the change; changed high at edge 8 for one cycle.
REQ-032 switch toggles 0->3->0 with pulses 2 cycles long -> code stays 0; changed never asserts.
REQ-033 AUTO_DIV=3, dir=1, code=6, auto_en=1 -> code runs 6,7,0,1 with one step every 3 cycles; one changed pulse per step.
REQ-034 RUN, dir=0, code=1; press btn -> code frozen at PAUSE entry; press again -> resumes from the held prescaler; sequence continues 0,7,6.
REQ-035 In PAUSE, auto_en falls and btn is pressed in the same debounced cycle -> state IDLE; code loads switch.
REQ-036 Assert rst_n low mid-RUN between clock edges -> code=0 and changed=0 immediately; after release, state is IDLE.
